// File: rtl/tx_pkg.sv
// Shared types and constants for the Interlaken TX burst scheduler
// and the downstream framer.
package tx_pkg;

    localparam int WORD_W = 64;

    localparam logic [63:0] IDLE_CTRL_WORD  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] BURST_CTRL_WORD = 64'hC000_0000_0000_0000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_burst_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
// Returns a one-hot grant and its encoded index.
module rr_arbiter
    import tx_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [CH_W-1:0]   o_idx
);

    logic w_found;
    int   w_c;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_c     = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_c = (int'(i_ptr) + i) % NUM_CH;
            if (!w_found && i_req[w_c]) begin
                w_found    = 1'b1;
                o_gnt[w_c] = 1'b1;
                o_idx      = CH_W'(w_c);
            end
        end
    end

endmodule

// File: rtl/tx_burst_scheduler.sv
// Round-robin burst scheduler feeding one 64-bit slot of the Interlaken
// TX framer; bursts end at packet end or after BURST_MAX words.
module tx_burst_scheduler
    import tx_pkg::*;
#(
    parameter  int NUM_CH    = 2,
    parameter  int BURST_MAX = 8,
    localparam int CH_W      = ch_w(NUM_CH)
) (
    input  logic                     USER_CLK,
    input  logic                     SYSTEM_RESET_N,
    input  logic [WORD_W*NUM_CH-1:0] CH_DATA,
    input  logic [NUM_CH-1:0]        CH_VALID,
    input  logic [NUM_CH-1:0]        CH_SOP,
    input  logic [NUM_CH-1:0]        CH_EOP,
    output logic [NUM_CH-1:0]        CH_READY,
    input  logic                     TX_READY,
    output logic [WORD_W-1:0]        TX_DATA,
    output logic                     TX_DATA_TO_SEND,
    output logic [CH_W-1:0]          TX_CHANNEL,
    output logic                     TX_SOP,
    output logic                     TX_EOP,
    output logic                     TX_BURST_START
);

    localparam int CNT_W = $clog2(BURST_MAX) + 1;

    state_t            r_state;
    state_t            w_next;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   r_grant;
    logic [CH_W-1:0]   w_arb_idx;
    logic [NUM_CH-1:0] w_arb_gnt;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic              r_first_pending;
    logic              r_ob_valid;
    logic [WORD_W-1:0] r_tx_data;
    logic [CH_W-1:0]   r_tx_ch;
    logic              r_tx_sop;
    logic              r_tx_eop;
    logic              r_tx_bs;
    logic [WORD_W-1:0] w_ch_data;
    logic              w_accept;
    logic              w_any;
    logic              w_xfer;
    logic              w_end;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .i_req (CH_VALID),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

    assign w_accept  = !r_ob_valid || TX_READY;
    assign w_any     = |w_arb_gnt;
    assign w_ch_data = CH_DATA[WORD_W*int'(r_grant) +: WORD_W];
    assign w_xfer    = (r_state == ST_BURST) && CH_VALID[r_grant] && w_accept;
    // EOP and the burst limit on the same word close a single burst
    assign w_end     = w_xfer && (CH_EOP[r_grant] ||
                       r_burst_cnt == CNT_W'(BURST_MAX - 1));

    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) r_state <= ST_IDLE;
        else                 r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_any) w_next = ST_BURST;
            ST_BURST: if (w_end) w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        CH_READY = '0;
        if (r_state == ST_BURST) CH_READY[r_grant] = w_accept;
    end

    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            r_rr_ptr        <= CH_W'(NUM_CH - 1);
            r_grant         <= '0;
            r_burst_cnt     <= '0;
            r_first_pending <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_any) begin
                r_grant         <= w_arb_idx;
                r_burst_cnt     <= '0;
                r_first_pending <= 1'b1;
            end
            if (w_xfer) begin
                r_first_pending <= 1'b0;
                r_burst_cnt     <= w_end ? '0 : r_burst_cnt + CNT_W'(1);
            end
            if (w_end) r_rr_ptr <= r_grant;
        end
    end

    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            r_ob_valid <= 1'b0;
            r_tx_data  <= '0;
            r_tx_ch    <= '0;
            r_tx_sop   <= 1'b0;
            r_tx_eop   <= 1'b0;
            r_tx_bs    <= 1'b0;
        end else if (w_xfer) begin
            r_ob_valid <= 1'b1;
            r_tx_data  <= w_ch_data;
            r_tx_ch    <= r_grant;
            r_tx_sop   <= CH_SOP[r_grant];
            r_tx_eop   <= CH_EOP[r_grant];
            r_tx_bs    <= r_first_pending;
        end else if (TX_READY) begin
            r_ob_valid <= 1'b0;
        end
    end

    assign TX_DATA         = r_tx_data;
    assign TX_DATA_TO_SEND = r_ob_valid;
    assign TX_CHANNEL      = r_tx_ch;
    assign TX_SOP          = r_tx_sop;
    assign TX_EOP          = r_tx_eop;
    assign TX_BURST_START  = r_tx_bs;

endmodule

// File: tb/tb_tx_burst_scheduler.sv
// Directed bench for tx_burst_scheduler (2 channels, BURST_MAX = 4).
// Output words are logged on consume and compared with hand-built lists.
module tb_tx_burst_scheduler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [127:0] ch_data = '0;
    logic [1:0]   ch_valid = '0;
    logic [1:0]   ch_sop = '0;
    logic [1:0]   ch_eop = '0;
    logic [1:0]   ch_ready;
    logic         tx_ready = 1'b0;
    logic [63:0]  tx_data;
    logic         tx_send;
    logic [0:0]   tx_ch;
    logic         tx_sop;
    logic         tx_eop;
    logic         tx_bs;

    int checks = 0;
    int failures = 0;

    logic [65:0] q0[$];
    logic [65:0] q1[$];
    logic [67:0] obs[$];
    logic [67:0] exq[$];
    logic        gap0 = 1'b0;
    logic        gap1 = 1'b0;

    always #5 clk = ~clk;

    tx_burst_scheduler #(.NUM_CH(2), .BURST_MAX(4)) dut (
        .USER_CLK        (clk),
        .SYSTEM_RESET_N  (rst_n),
        .CH_DATA         (ch_data),
        .CH_VALID        (ch_valid),
        .CH_SOP          (ch_sop),
        .CH_EOP          (ch_eop),
        .CH_READY        (ch_ready),
        .TX_READY        (tx_ready),
        .TX_DATA         (tx_data),
        .TX_DATA_TO_SEND (tx_send),
        .TX_CHANNEL      (tx_ch),
        .TX_SOP          (tx_sop),
        .TX_EOP          (tx_eop),
        .TX_BURST_START  (tx_bs)
    );

    task automatic chk(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int ch, input int n);
        return {32'(ch + 1), 32'(n)};
    endfunction

    function automatic logic [67:0] cur();
        return {tx_bs, tx_sop, tx_eop, tx_ch, tx_data};
    endfunction

    task automatic load_pkt(input int ch, input int len, input int first);
        logic [65:0] e;
        for (int k = 0; k < len; k++) begin
            e = {k == 0, k == len - 1, mk(ch, first + k)};
            if (ch == 0) q0.push_back(e);
            else         q1.push_back(e);
        end
    endtask

    task automatic expw(input int ch, input int n, input logic sop,
                        input logic eop, input logic bs);
        exq.push_back({bs, sop, eop, 1'(ch), mk(ch, n)});
    endtask

    task automatic drive();
        ch_valid[0] = (q0.size() != 0) && !gap0;
        ch_valid[1] = (q1.size() != 0) && !gap1;
        ch_sop = '0;
        ch_eop = '0;
        ch_data = '0;
        if (q0.size() != 0) begin
            ch_sop[0] = q0[0][65];
            ch_eop[0] = q0[0][64];
            ch_data[63:0] = q0[0][63:0];
        end
        if (q1.size() != 0) begin
            ch_sop[1] = q1[0][65];
            ch_eop[1] = q1[0][64];
            ch_data[127:64] = q1[0][63:0];
        end
    endtask

    task automatic tick();
        logic f0, f1;
        @(negedge clk);
        f0 = ch_valid[0] && ch_ready[0];
        f1 = ch_valid[1] && ch_ready[1];
        if (tx_ready && tx_send) obs.push_back(cur());
        @(posedge clk);
        #1;
        if (f0) void'(q0.pop_front());
        if (f1) void'(q1.pop_front());
        drive();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        gap0 = 1'b0;
        gap1 = 1'b0;
        tx_ready = 1'b1;
        drive();
        repeat (2) tick();
        rst_n = 1'b1;
        obs.delete();
        exq.delete();
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 72'(obs.size()), 72'(exq.size()));
        foreach (exq[i])
            chk($sformatf("%s_w%0d", tag, i),
                72'((i < obs.size()) ? obs[i] : '1), 72'(exq[i]));
        obs.delete();
        exq.delete();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #2;
        chk("rst_send", 72'(tx_send), 72'(0));
        chk("rst_rdy", 72'(ch_ready), 72'(0));
        chk("rst_out", 72'(cur()), 72'(0));

        // single channel, three words
        reset_dut();
        load_pkt(0, 3, 1);
        drive();
        tick();
        chk("t1_idle_send", 72'(tx_send), 72'(0));
        chk("t1_idle_rdy", 72'(ch_ready), 72'(2'b01));
        tick();
        chk("t1_a1_send", 72'(tx_send), 72'(1));
        chk("t1_a1", 72'(cur()), 72'({1'b1, 1'b1, 1'b0, 1'b0, mk(0, 1)}));
        tick();
        chk("t1_a2", 72'(cur()), 72'({1'b0, 1'b0, 1'b0, 1'b0, mk(0, 2)}));
        tick();
        chk("t1_a3", 72'(cur()), 72'({1'b0, 1'b0, 1'b1, 1'b0, mk(0, 3)}));
        tick();
        chk("t1_done_send", 72'(tx_send), 72'(0));

        // fairness, 2-word packets on both channels
        reset_dut();
        load_pkt(0, 2, 1); load_pkt(0, 2, 3);
        load_pkt(1, 2, 1); load_pkt(1, 2, 3);
        drive();
        repeat (20) tick();
        expw(0, 1, 1, 0, 1); expw(0, 2, 0, 1, 0);
        expw(1, 1, 1, 0, 1); expw(1, 2, 0, 1, 0);
        expw(0, 3, 1, 0, 1); expw(0, 4, 0, 1, 0);
        expw(1, 3, 1, 0, 1); expw(1, 4, 0, 1, 0);
        check_log("fair");

        // burst limit: 10-word packet against a 1-word packet
        reset_dut();
        load_pkt(0, 10, 1);
        load_pkt(1, 1, 1);
        drive();
        repeat (25) tick();
        expw(0, 1, 1, 0, 1); expw(0, 2, 0, 0, 0);
        expw(0, 3, 0, 0, 0); expw(0, 4, 0, 0, 0);
        expw(1, 1, 1, 1, 1);
        expw(0, 5, 0, 0, 1); expw(0, 6, 0, 0, 0);
        expw(0, 7, 0, 0, 0); expw(0, 8, 0, 0, 0);
        expw(0, 9, 0, 0, 1); expw(0, 10, 0, 1, 0);
        check_log("blim");

        // backpressure 1,0,0,1 during a burst
        reset_dut();
        load_pkt(0, 4, 1);
        drive();
        tick();
        tick();
        chk("bp_w1", 72'(cur()), 72'({1'b1, 1'b1, 1'b0, 1'b0, mk(0, 1)}));
        tick();
        tx_ready = 1'b0;
        #1;
        chk("bp_rdy_lo0", 72'(ch_ready), 72'(0));
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("bp_hold%0d", k), 72'(cur()),
                72'({1'b0, 1'b0, 1'b0, 1'b0, mk(0, 2)}));
            chk($sformatf("bp_send%0d", k), 72'(tx_send), 72'(1));
            chk($sformatf("bp_rdy%0d", k), 72'(ch_ready), 72'(0));
        end
        tx_ready = 1'b1;
        #1;
        chk("bp_rdy_back", 72'(ch_ready), 72'(2'b01));
        repeat (8) tick();
        expw(0, 1, 1, 0, 1); expw(0, 2, 0, 0, 0);
        expw(0, 3, 0, 0, 0); expw(0, 4, 0, 1, 0);
        check_log("bp");

        // source gap on ch1 with ch0 waiting
        reset_dut();
        load_pkt(1, 4, 1);
        drive();
        repeat (3) tick();
        gap1 = 1'b1;
        load_pkt(0, 2, 1);
        drive();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("gap_rdy%0d", k), 72'(ch_ready), 72'(2'b10));
        end
        gap1 = 1'b0;
        drive();
        repeat (15) tick();
        expw(1, 1, 1, 0, 1); expw(1, 2, 0, 0, 0);
        expw(1, 3, 0, 0, 0); expw(1, 4, 0, 1, 0);
        expw(0, 1, 1, 0, 1); expw(0, 2, 0, 1, 0);
        check_log("gap");

        // asynchronous reset mid-burst
        reset_dut();
        load_pkt(1, 4, 1);
        drive();
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_send", 72'(tx_send), 72'(0));
        chk("mrst_rdy", 72'(ch_ready), 72'(0));
        chk("mrst_out", 72'(cur()), 72'(0));
        q0.delete();
        q1.delete();
        load_pkt(0, 2, 1);
        load_pkt(1, 2, 1);
        drive();
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("mrst_idle_send", 72'(tx_send), 72'(0));
        chk("mrst_idle_rdy", 72'(ch_ready), 72'(2'b01));
        tick();
        chk("mrst_first", 72'(cur()), 72'({1'b1, 1'b1, 1'b0, 1'b0, mk(0, 1)}));
        chk("mrst_first_send", 72'(tx_send), 72'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
